// File: rtl/ecs8_pio_irq_if.sv
// Avalon-MM slave bus bundle for ecs8_pio_irq.
// Latency: reads return one cycle after avs_read; writes complete on the strobe cycle.
// Backpressure: none, because the slave never inserts wait states.
// Signals: avs_address (3b word address), avs_read, avs_write, avs_writedata (32b),
//          avs_readdata (32b, driven by the slave).
interface ecs8_pio_irq_if;
  logic [2:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata
  );
endinterface

// File: rtl/ecs8_pio_irq.sv
// ecs8 PIO peripheral: synchronised, optionally debounced inputs with edge-capture irq,
// and register-driven outputs with atomic set/clear.
// Latency: registered read data (+1 cycle); inputs reach DATA after 2 sync edges plus the
// debounce window, or after the 3rd edge when debounce is compiled out.
// Backpressure: none, because the Avalon slave always accepts requests with zero wait states.
//
// Optional feature macro: ECS8_PIO_IRQ_DBNC_EN (per-bit debounce counters).
// Ports:
//   clk, rst_n     - system clock, asynchronous active-low reset
//   pio_in  [IW]   - asynchronous input pins
//   pio_out [OW]   - output register
//   irq            - OR of (edge & mask), taken from flops only
//   avs            - Avalon-MM slave (ecs8_pio_irq_if.slave)
// Register map (word address): 0 DATA(R), 1 OUT(RW), 2 MASK(RW), 3 EDGE(R/W1C),
//   4 RISE_EN(RW), 5 FALL_EN(RW), 6 OUT_SET(W), 7 OUT_CLR(W).
module ecs8_pio_irq #(
  parameter int            IW       = 4,
  parameter int            OW       = 2,
  parameter logic [IW-1:0] IN_RST   = '0,
  parameter logic [OW-1:0] OUT_RST  = '0,
  parameter int            DBNC_CNT = 32768
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [IW-1:0]        pio_in,
  output logic [OW-1:0]        pio_out,
  output logic                 irq,
  ecs8_pio_irq_if.slave        avs
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_OUT     = 3'd1;
  localparam logic [2:0] A_MASK    = 3'd2;
  localparam logic [2:0] A_EDGE    = 3'd3;
  localparam logic [2:0] A_RISE_EN = 3'd4;
  localparam logic [2:0] A_FALL_EN = 3'd5;
  localparam logic [2:0] A_OUT_SET = 3'd6;
  localparam logic [2:0] A_OUT_CLR = 3'd7;

  logic [IW-1:0] s1, s2;
  logic [IW-1:0] state, state_nxt;
  logic [IW-1:0] mask, rise_en, fall_en, edge_cap;
  logic [IW-1:0] edge_evt, w1c;
  logic [IW-1:0] wd_in;
  logic [OW-1:0] wd_out;
  logic [31:0]   rd_val;
  logic          unused_wd;

  assign wd_in  = avs.avs_writedata[IW-1:0];
  assign wd_out = avs.avs_writedata[OW-1:0];
  // Upper write-data bits are architecturally ignored.
  assign unused_wd = ^avs.avs_writedata;

  // Two-flop synchroniser; reset to the pins' idle level so no edge fires on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= IN_RST;
      s2 <= IN_RST;
    end else begin
      s1 <= pio_in;
      s2 <= s1;
    end
  end

`ifdef ECS8_PIO_IRQ_DBNC_EN
  localparam int CW = $clog2(DBNC_CNT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DBNC_CNT - 1);

  // A bit is accepted only once s2 has disagreed with state for DBNC_CNT consecutive edges;
  // any agreement in between restarts the count.
  for (genvar i = 0; i < IW; i++) begin : g_dbnc
    logic [CW-1:0] cnt;
    logic          differ;

    assign differ       = s2[i] ^ state[i];
    assign state_nxt[i] = (differ && cnt == CNT_LAST) ? s2[i] : state[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (!differ || cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
`else
  assign state_nxt = s2;
`endif

  // Edge events are detected against the state being loaded on this very edge.
  assign edge_evt = (state_nxt & ~state & rise_en) | (~state_nxt & state & fall_en);
  assign w1c      = (avs.avs_write && avs.avs_address == A_EDGE) ? wd_in : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IN_RST;
      edge_cap <= '0;
    end else begin
      state    <= state_nxt;
      // A new event on the same bit overrides a simultaneous software clear.
      edge_cap <= (edge_cap & ~w1c) | edge_evt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pio_out <= OUT_RST;
      mask    <= '0;
      rise_en <= '0;
      fall_en <= '0;
    end else if (avs.avs_write) begin
      case (avs.avs_address)
        A_OUT:     pio_out <= wd_out;
        A_MASK:    mask    <= wd_in;
        A_RISE_EN: rise_en <= wd_in;
        A_FALL_EN: fall_en <= wd_in;
        A_OUT_SET: pio_out <= pio_out | wd_out;
        A_OUT_CLR: pio_out <= pio_out & ~wd_out;
        default:   ;
      endcase
    end
  end

  // Read mux uses pre-write register values, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    case (avs.avs_address)
      A_DATA:    rd_val = 32'(state);
      A_OUT:     rd_val = 32'(pio_out);
      A_MASK:    rd_val = 32'(mask);
      A_EDGE:    rd_val = 32'(edge_cap);
      A_RISE_EN: rd_val = 32'(rise_en);
      A_FALL_EN: rd_val = 32'(fall_en);
      default:   rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avs.avs_readdata <= '0;
    end else if (avs.avs_read) begin
      avs.avs_readdata <= rd_val;
    end
  end

  assign irq = |(edge_cap & mask);

endmodule

// File: doc/ecs8_pio_irq.md
Name: ecs8_pio_irq

Overview:
- Parametrised general-purpose I/O peripheral for the ecs8 Nios II system, replacing ad-hoc button/switch/LED/RTC-IRQ wiring.
- Inputs: IW pins, each synchronised and debounced, with per-bit rise/fall edge capture and a maskable interrupt.
- Outputs: OW register-driven pins with atomic set/clear.
- Attaches to the system as an Avalon-MM slave with fixed 1-cycle read latency.

Parameters:
- IW, 4, number of input pins, 1..32.
- OW, 2, number of output pins, 1..32.
- IN_RST, 0, reset value of the synchroniser and input-state flops, IW bits; set to the pins' idle level to avoid spurious edges after reset.
- OUT_RST, 0, reset value of the output register, OW bits.
- DBNC_CNT, 32768, stable cycles required before an input change is accepted (1 ms at 32.768 MHz), 2..65535.

Ports:
- clk  in  1  system clock, 32.768 MHz
- rst_n  in  1  asynchronous active-low reset
- pio_in  in  IW  asynchronous input pins
- pio_out  out  OW  output register
- avs_address  in  3  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_readdata  out  32  read data, valid 1 cycle after avs_read
- irq  out  1  interrupt request, active-high

Behaviour:
- Reset state:
  - sync flops and input state = IN_RST
  - pio_out = OUT_RST
  - mask, rise_en, fall_en, edge = 0
  - avs_readdata = 0, irq = 0
  - debounce counters = 0
- Input path: pio_in passes through a 2-flop synchroniser (s1, s2).
- Debounce, per bit:
  - If s2 equals state, the counter clears.
  - Otherwise the counter increments.
  - When the counter equals DBNC_CNT-1 with s2 still differing, state takes s2 and the counter clears.
  - A glitch shorter than DBNC_CNT cycles never changes state.
- Edge capture, per bit:
  - edge[i] sets on the clock edge where state[i] rises with rise_en[i]=1, or falls with fall_en[i]=1.
  - The bit stays set until cleared by software.
- Register map (word address; unused bits read 0; writes to read-only registers ignored):
  - 0 DATA: R, input state.
  - 1 OUT: RW, pio_out.
  - 2 MASK: RW, irq mask.
  - 3 EDGE: R; write-1-to-clear.
  - 4 RISE_EN: RW.
  - 5 FALL_EN: RW.
  - 6 OUT_SET: W; 1 bits set pio_out; reads 0.
  - 7 OUT_CLR: W; 1 bits clear pio_out; reads 0.
- Write timing: writes take effect on the clock edge where avs_write=1; no wait states.
- Read timing:
  - avs_readdata is registered: data for the cycle-N request appears in cycle N+1.
  - avs_readdata holds its value until the next read.
- Read and write in the same cycle: write is performed, read returns the pre-write value.
- Simultaneous edge event and W1C on the same bit: the set wins, edge stays 1.
- irq = OR over (edge & mask) of registered values; it is driven only from flops, with no combinational path from the bus.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Edges pending before reset are lost.
- Widths: registers narrower than 32 bits are zero-extended on read. Write data above IW/OW is ignored.

Optional Feature:
- Macro: ECS8_PIO_IRQ_DBNC_EN.
- Defined: debounce counters are present as specified above.
  - Acceptance latency from a pin change to DATA is 2 sync cycles + DBNC_CNT cycles.
- Undefined:
  - No counters are instantiated and DBNC_CNT is ignored.
  - state <= s2 every cycle; a pin change reaches DATA 3 clock edges after sampling.
  - Glitches of 1 cycle or longer are captured as edges.

Test Plan:
- Reset: rst_n low with IN_RST=4'b0011, OUT_RST=2'b10 -> pio_out=2'b10; DATA read returns 0x3; irq=0; EDGE read returns 0.
- Debounce (macro on, DBNC_CNT=4): pio_in[0] pulses high for 3 cycles -> DATA unchanged, edge=0. Held high for 10 cycles -> DATA bit0=1 exactly 2+4 cycles after the change.
- Edge/irq: write RISE_EN=1, MASK=1; raise pio_in[0] -> EDGE=0x1 and irq=1. Write EDGE=0x1 -> irq=0 the next cycle. Fall of the pin with FALL_EN=0 -> no edge.
- W1C collision: a new rising edge on bit0 arrives on the same cycle as an EDGE write of 0x1 -> EDGE bit0 stays 1, irq stays 1.
- Outputs: write OUT=0x0, OUT_SET=0x3, then OUT_CLR=0x1 -> pio_out=2'b11, then 2'b10. Reads of addresses 6 and 7 return 0.
- Read latency: avs_read at address 1 in cycle N -> avs_readdata=0x2 in cycle N+1. A simultaneous write of OUT=0x1 in cycle N still reads 0x2.
